jtkcpu_stack_seq: RTL and testbench

// Byte-serial PSH/PUL sequencer for the register file's stack port. Takes an 8-bit

---
 rtl/jtkcpu_stack_seq.sv | 144 ++++++++++++++
 tb/tb_jtkcpu_stack_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_stack_seq.sv
// jtkcpu_stack_seq
// Byte-serial PSH/PUL sequencer for the register file's stack port.
// Walks an 8-bit postbyte register mask one byte at a time and drives the
// register file stack controls and the bus read/write strobes.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   cen             clock enable; state advances only on enabled edges
//   start           sequence request, sampled in IDLE only
//   pull            0 = push, 1 = pull (sampled with start)
//   ussel           0 = S stack, 1 = U stack (sampled with start)
//   mask[7:0]       postbyte mask (7 PC, 6 U/S, 5 Y, 4 X, 3 DP, 2 B, 1 A, 0 CC)
//   bus_ok          bus ready; low stalls WR and RD
//   psh_sel[7:0]    registers not yet fully transferred
//   psh_hihalf      current byte is the high half of a 16-bit register
//   psh_ussel       latched stack select
//   pul_en          pull read in progress (RD)
//   psh_dec         pre-decrement stack pointer (DEC)
//   stack_busy      stack pointer update this cycle (DEC or LATCH)
//   wr, rd          bus strobes
//   busy            sequence in progress
//   done            one-cycle pulse at sequence end (FIN)
module jtkcpu_stack_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       start,
    input  logic       pull,
    input  logic       ussel,
    input  logic [7:0] mask,
    input  logic       bus_ok,
    output logic [7:0] psh_sel,
    output logic       psh_hihalf,
    output logic       psh_ussel,
    output logic       pul_en,
    output logic       psh_dec,
    output logic       stack_busy,
    output logic       wr,
    output logic       rd,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, DEC, WR, RD, LATCH, FIN} state_t;

    state_t     st, st_nx;
    logic [7:0] sel_nx, adv_sel;
    logic       hi_nx, adv_hi;
    logic       pull_r, pull_nx, us_nx;
    logic [2:0] cur;

    // Highest set bit: push order starts from PC downwards
    function automatic logic [2:0] top_bit(input logic [7:0] m);
        top_bit = 3'd0;
        for (int i = 0; i < 8; i++)
            if (m[i]) top_bit = i[2:0];
    endfunction

    // Lowest set bit: pull order starts from CC upwards
    function automatic logic [2:0] low_bit(input logic [7:0] m);
        low_bit = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) low_bit = i[2:0];
    endfunction

    // Half selected for the first byte of a register. Push stores the low
    // byte first, pull restores the high byte first; bits 7..4 are 16-bit.
    function automatic logic first_hi(input logic [7:0] m, input logic pl);
        first_hi = pl && (m != 8'd0) && low_bit(m)[2];
    endfunction

    // Byte advance: finish the other half of a 16-bit register if it is
    // still pending, otherwise retire the register and set up the next one.
    always_comb begin
        cur     = pull_r ? low_bit(psh_sel) : top_bit(psh_sel);
        adv_sel = psh_sel;
        adv_hi  = psh_hihalf;
        if (cur[2] && (psh_hihalf == pull_r)) begin
            adv_hi = ~psh_hihalf;
        end else begin
            adv_sel = psh_sel & ~(8'd1 << cur);
            adv_hi  = first_hi(adv_sel, pull_r);
        end
    end

    always_comb begin
        st_nx   = st;
        sel_nx  = psh_sel;
        hi_nx   = psh_hihalf;
        pull_nx = pull_r;
        us_nx   = psh_ussel;
        case (st)
            IDLE: if (start) begin
                sel_nx  = mask;
                pull_nx = pull;
                us_nx   = ussel;
                hi_nx   = first_hi(mask, pull);
                if (mask == 8'd0) st_nx = FIN;
                else              st_nx = pull ? RD : DEC;
            end
            DEC: st_nx = WR;
            WR: if (bus_ok) begin
                sel_nx = adv_sel;
                hi_nx  = adv_hi;
                st_nx  = (adv_sel != 8'd0) ? DEC : FIN;
            end
            RD: if (bus_ok) st_nx = LATCH;
            // selection held through LATCH so the captured byte lands in
            // the right register; advance only on the way out
            LATCH: begin
                sel_nx = adv_sel;
                hi_nx  = adv_hi;
                st_nx  = (adv_sel != 8'd0) ? RD : FIN;
            end
            FIN:     st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            psh_sel    <= 8'd0;
            psh_hihalf <= 1'b0;
            psh_ussel  <= 1'b0;
            pull_r     <= 1'b0;
        end else if (cen) begin
            st         <= st_nx;
            psh_sel    <= sel_nx;
            psh_hihalf <= hi_nx;
            psh_ussel  <= us_nx;
            pull_r     <= pull_nx;
        end
    end

    assign psh_dec    = (st == DEC);
    assign wr         = (st == WR);
    assign rd         = (st == RD);
    assign pul_en     = (st == RD);
    assign stack_busy = (st == DEC) || (st == LATCH);
    assign busy       = (st != IDLE);
    assign done       = (st == FIN);

endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
module tb_jtkcpu_stack_seq;

    logic       clk = 0, rst = 1, cen = 1, start = 0, pull = 0, ussel = 0, bus_ok = 1;
    logic [7:0] mask = 0;
    logic [7:0] psh_sel;
    logic       psh_hihalf, psh_ussel, pul_en, psh_dec, stack_busy, wr, rd, busy, done;

    jtkcpu_stack_seq dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start), .pull(pull), .ussel(ussel),
        .mask(mask), .bus_ok(bus_ok), .psh_sel(psh_sel), .psh_hihalf(psh_hihalf),
        .psh_ussel(psh_ussel), .pul_en(pul_en), .psh_dec(psh_dec),
        .stack_busy(stack_busy), .wr(wr), .rd(rd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int n_dec, n_sb, n_wr, n_rd, n_busy, n_done, done_at, sb_bad, sel_chg, us_bad;
    logic [8:0] trn[$];
    logic [8:0] exq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one sequence; stall = WR/RD cycles with bus_ok low before the
    // first accepted transfer, restart_at = cycle at which start is re-pulsed
    task automatic run(input logic [7:0] m, input logic pl, input logic us,
                       input int stall, input int restart_at);
        int stl;
        trn.delete();
        n_dec = 0; n_sb = 0; n_wr = 0; n_rd = 0; n_busy = 0; n_done = 0;
        done_at = 0; sb_bad = 0; sel_chg = 0; us_bad = 0; stl = stall;
        mask = m; pull = pl; ussel = us; start = 1; bus_ok = 1;
        step();
        start = 0; mask = 8'h5A; ussel = ~us; pull = ~pl;
        for (int c = 1; c <= 60; c++) begin
            if (psh_dec) n_dec++;
            if (stack_busy) n_sb++;
            if (wr) n_wr++;
            if (rd) n_rd++;
            if (busy) begin
                n_busy++;
                if (psh_ussel !== us) us_bad++;
            end
            if (stack_busy && (rd || wr)) sb_bad++;
            if (stack_busy && !psh_dec && trn.size() > 0 &&
                {psh_sel, psh_hihalf} !== trn[trn.size()-1]) sel_chg++;
            if (done) begin
                n_done++;
                if (done_at == 0) done_at = c;
            end
            if ((wr || rd) && stl > 0) begin
                bus_ok = 0;
                stl--;
            end else bus_ok = 1;
            if ((wr || rd) && bus_ok) trn.push_back({psh_sel, psh_hihalf});
            start = (c == restart_at);
            if (done_at != 0 && c >= done_at + 3) break;
            step();
        end
        start = 0; bus_ok = 1;
        if (done_at == 0) chk("timeout_no_done", 0, 1);
    endtask

    task automatic cmp_trace(input string tag);
        chk({tag, "_count"}, trn.size(), exq.size());
        for (int i = 0; i < exq.size() && i < trn.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), trn[i], exq[i]);
    endtask

    initial begin
        #2;
        chk("rst_sel", psh_sel, 0);
        chk("rst_flags", {psh_hihalf, psh_ussel, pul_en, psh_dec, stack_busy, wr, rd, busy, done}, 0);
        step();
        rst = 0;
        step();

        // push 0x86: PC lo, PC hi, B, A
        run(8'h86, 0, 0, 0, 0);
        exq = '{9'h10C, 9'h10D, 9'h00C, 9'h004};
        cmp_trace("push86");
        chk("push86_dec", n_dec, 4);
        chk("push86_wr", n_wr, 4);
        chk("push86_rd", n_rd, 0);
        chk("push86_done_at", done_at, 9);
        chk("push86_ndone", n_done, 1);
        chk("push86_busy", n_busy, 9);
        chk("push86_sb_overlap", sb_bad, 0);
        chk("push86_ussel", us_bad, 0);

        // pull 0x86 on U: A, B, PC hi, PC lo
        run(8'h86, 1, 1, 0, 0);
        exq = '{9'h10C, 9'h108, 9'h101, 9'h100};
        cmp_trace("pull86");
        chk("pull86_sb", n_sb, 4);
        chk("pull86_sb_overlap", sb_bad, 0);
        chk("pull86_latch_stable", sel_chg, 0);
        chk("pull86_dec", n_dec, 0);
        chk("pull86_done_at", done_at, 9);
        chk("pull86_ussel", us_bad, 0);
        chk("pull86_end_sel", psh_sel, 0);

        // empty mask
        run(8'h00, 0, 0, 0, 0);
        chk("m0_done_at", done_at, 1);
        chk("m0_busy", n_busy, 1);
        chk("m0_strobes", n_wr + n_rd + n_dec, 0);

        // push 0x01 with 3 stalled WR cycles
        run(8'h01, 0, 0, 3, 0);
        exq = '{9'h002};
        cmp_trace("stall");
        chk("stall_wr", n_wr, 4);
        chk("stall_dec", n_dec, 1);
        chk("stall_done_at", done_at, 6);

        // pull 0xFF with start re-pulsed mid sequence
        run(8'hFF, 1, 0, 0, 5);
        exq = '{9'h1FE, 9'h1FC, 9'h1F8, 9'h1F0, 9'h1E1, 9'h1E0,
                9'h1C1, 9'h1C0, 9'h181, 9'h180, 9'h101, 9'h100};
        cmp_trace("pullFF");
        chk("pullFF_ndone", n_done, 1);
        chk("pullFF_done_at", done_at, 25);
        chk("pullFF_idle", busy, 0);

        // reset during WR of push 0x30
        mask = 8'h30; pull = 0; ussel = 1; start = 1;
        step();
        start = 0;
        chk("rstmid_dec", psh_dec, 1);
        step();
        chk("rstmid_wr", wr, 1);
        #2 rst = 1;
        #1;
        chk("rstmid_sel", psh_sel, 0);
        chk("rstmid_flags", {psh_hihalf, psh_ussel, pul_en, psh_dec, stack_busy, wr, rd, busy, done}, 0);
        step();
        rst = 0;
        step();
        run(8'h30, 0, 0, 0, 0);
        exq = '{9'h060, 9'h061, 9'h020, 9'h021};
        cmp_trace("after_rst");
        chk("after_rst_done_at", done_at, 9);

        // cen low freezes the sequencer
        mask = 8'h01; pull = 0; ussel = 0; start = 1;
        step();
        start = 0; cen = 0;
        step();
        step();
        chk("cen_hold", {psh_dec, wr, busy, psh_sel}, {3'b101, 8'h01});
        cen = 1;
        step();
        chk("cen_resume", {psh_dec, wr}, 2'b01);
        step();
        chk("cen_fin", done, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
